// File: rtl/psram_pkg.sv
// Shared constants, state encoding and frame layout for the SPI PSRAM controller.
package psram_pkg;

   localparam int unsigned FRAME_BITS = 64;
   localparam int unsigned CMD_BITS   = 8;
   localparam int unsigned RX_BITS    = 32;
   localparam int unsigned LEN_W      = $clog2(FRAME_BITS + 1);

   localparam logic [7:0] CMD_RSTEN = 8'h66;
   localparam logic [7:0] CMD_RST   = 8'h99;
   localparam logic [7:0] CMD_WRITE = 8'h02;
   localparam logic [7:0] CMD_READ  = 8'h03;

   typedef enum logic [2:0] {
      ST_WAIT, ST_RSTEN, ST_GAP1, ST_RST, ST_GAP2, ST_IDLE, ST_SHIFT, ST_GAP3
   } state_t;

   typedef struct packed {
      logic [7:0]  cmd;
      logic [23:0] addr;
      logic [31:0] data;
   } frame_t;

   // Word access frame: command, 24-bit address with MSB clear, data (zero for reads).
   function automatic frame_t access_frame(input logic write, input logic [22:0] addr,
                                           input logic [31:0] wdata);
      frame_t f;
      f.cmd  = write ? CMD_WRITE : CMD_READ;
      f.addr = {1'b0, addr};
      f.data = write ? wdata : 32'h0;
      return f;
   endfunction

endpackage

// File: rtl/psram_shifter.sv
// SPI mode-0 bit engine: two clk cycles per bit, MSB first, ram_so sampled at the end of each high phase.
module psram_shifter
   import psram_pkg::*;
(
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [FRAME_BITS-1:0] frame,
   input  logic [LEN_W-1:0]      nbits,
   input  logic                  ram_so,
   output logic                  ram_clk,
   output logic                  ram_si,
   output logic                  last_c,
   output logic [RX_BITS-1:0]    rx_next_c
);

   logic                  busy;
   logic [FRAME_BITS-1:0] sr;
   logic [LEN_W-1:0]      left;
   logic [RX_BITS-2:0]    rx;

   // ram_clk doubles as the phase flag; last_c marks the final high phase.
   assign last_c    = busy && ram_clk && (left == '0);
   assign rx_next_c = {rx, ram_so};

   always_ff @(posedge clk) begin
      if (reset) begin
         busy    <= 1'b0;
         ram_clk <= 1'b0;
         ram_si  <= 1'b0;
         sr      <= '0;
         left    <= '0;
         rx      <= '0;
      end else if (start) begin
         busy    <= 1'b1;
         ram_clk <= 1'b0;
         ram_si  <= frame[FRAME_BITS-1];
         sr      <= {frame[FRAME_BITS-2:0], 1'b0};
         left    <= nbits - LEN_W'(1);
      end else if (busy) begin
         if (!ram_clk) begin
            ram_clk <= 1'b1;
         end else begin
            ram_clk <= 1'b0;
            rx      <= rx_next_c[RX_BITS-2:0];
            if (left == '0) begin
               busy   <= 1'b0;
               ram_si <= 1'b0;
            end else begin
               ram_si <= sr[FRAME_BITS-1];
               sr     <= {sr[FRAME_BITS-2:0], 1'b0};
               left   <= left - LEN_W'(1);
            end
         end
      end
   end

endmodule

// File: rtl/psram_ctrl.sv
// PSRAM controller: power-up wait, 0x66/0x99 reset frames, then single-word SPI read/write frames.
module psram_ctrl
   import psram_pkg::*;
#(
   parameter int unsigned INIT_CYCLES = 7500,
   parameter int unsigned GAP_CYCLES  = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_write,
   input  logic [22:0] req_addr,
   input  logic [31:0] req_wdata,
   output logic [31:0] rdata,
   output logic        rvalid,
   output logic        wdone,
   output logic        init_done,
   output logic        ram_ce_b,
   output logic        ram_clk,
   output logic        ram_si,
   input  logic        ram_so
);

   localparam int unsigned CNT_MAX = (INIT_CYCLES > GAP_CYCLES) ? INIT_CYCLES : GAP_CYCLES;
   localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] GAP_LAST  = CNT_W'(GAP_CYCLES - 1);

   state_t                state;
   logic [CNT_W-1:0]      cnt;
   logic                  write_q;
   logic                  sh_start_c;
   logic [FRAME_BITS-1:0] sh_frame_c;
   logic [LEN_W-1:0]      sh_nbits_c;
   logic                  sh_last_c;
   logic [RX_BITS-1:0]    sh_rx_c;

   // Frame launch decision; must be combinational so the shifter starts on the same edge as ram_ce_b falls.
   always_comb begin
      sh_start_c = 1'b0;
      sh_frame_c = '0;
      sh_nbits_c = LEN_W'(CMD_BITS);
      case (state)
         ST_WAIT: if (cnt == INIT_LAST) begin
            sh_start_c = 1'b1;
            sh_frame_c[FRAME_BITS-1 -: CMD_BITS] = CMD_RSTEN;
         end
         ST_GAP1: if (cnt == GAP_LAST) begin
            sh_start_c = 1'b1;
            sh_frame_c[FRAME_BITS-1 -: CMD_BITS] = CMD_RST;
         end
         ST_IDLE: if (req_valid && req_ready) begin
            sh_start_c = 1'b1;
            sh_frame_c = access_frame(req_write, req_addr, req_wdata);
            sh_nbits_c = LEN_W'(FRAME_BITS);
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= ST_WAIT;
         cnt       <= '0;
         write_q   <= 1'b0;
         ram_ce_b  <= 1'b1;
         req_ready <= 1'b0;
         rvalid    <= 1'b0;
         wdone     <= 1'b0;
         init_done <= 1'b0;
         rdata     <= '0;
      end else begin
         rvalid <= 1'b0;
         wdone  <= 1'b0;
         case (state)
            ST_WAIT: if (sh_start_c) begin
               ram_ce_b <= 1'b0;
               state    <= ST_RSTEN;
            end else cnt <= cnt + CNT_W'(1);
            ST_RSTEN: if (sh_last_c) begin
               ram_ce_b <= 1'b1;
               cnt      <= '0;
               state    <= ST_GAP1;
            end
            ST_GAP1: if (sh_start_c) begin
               ram_ce_b <= 1'b0;
               state    <= ST_RST;
            end else cnt <= cnt + CNT_W'(1);
            ST_RST: if (sh_last_c) begin
               ram_ce_b <= 1'b1;
               cnt      <= '0;
               state    <= ST_GAP2;
            end
            ST_GAP2: if (cnt == GAP_LAST) begin
               init_done <= 1'b1;
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end else cnt <= cnt + CNT_W'(1);
            ST_IDLE: if (sh_start_c) begin
               ram_ce_b  <= 1'b0;
               req_ready <= 1'b0;
               write_q   <= req_write;
               state     <= ST_SHIFT;
            end
            ST_SHIFT: if (sh_last_c) begin
               ram_ce_b <= 1'b1;
               cnt      <= '0;
               state    <= ST_GAP3;
               if (write_q) begin
                  wdone <= 1'b1;
               end else begin
                  rvalid <= 1'b1;
                  rdata  <= sh_rx_c;
               end
            end
            ST_GAP3: if (cnt == GAP_LAST) begin
               req_ready <= 1'b1;
               state     <= ST_IDLE;
            end else cnt <= cnt + CNT_W'(1);
            default: state <= ST_WAIT;
         endcase
      end
   end

   psram_shifter u_shifter (
      .clk       (clk),
      .reset     (reset),
      .start     (sh_start_c),
      .frame     (sh_frame_c),
      .nbits     (sh_nbits_c),
      .ram_so    (ram_so),
      .ram_clk   (ram_clk),
      .ram_si    (ram_si),
      .last_c    (sh_last_c),
      .rx_next_c (sh_rx_c)
   );

endmodule

// File: doc/psram_ctrl.md
PSRAM_CTRL -- requirements
Module: psram_ctrl

Interface
REQ-001 Parameter INIT_CYCLES, default 7500; power-up wait in clk cycles (150 us at 50 MHz).
REQ-002 Parameter GAP_CYCLES, default 2; minimum clk cycles ram_ce_b stays high between frames.
REQ-003 clk  in  1  sole clock; all logic on posedge clk.
REQ-004 reset  in  1  synchronous, active-high reset.
REQ-005 req_valid  in  1  host request present.
REQ-006 req_ready  out  1  controller accepts a request this cycle.
REQ-007 req_write  in  1  1 = write word, 0 = read word.
REQ-008 req_addr  in  23  byte address; sent as 24-bit address with MSB 0.
REQ-009 req_wdata  in  32  write data; bits 31:24 go to req_addr.
REQ-010 rdata  out  32  read data; bits 31:24 come from req_addr; held until next read completes.
REQ-011 rvalid  out  1  one-cycle pulse on read completion.
REQ-012 wdone  out  1  one-cycle pulse on write completion.
REQ-013 init_done  out  1  high once the PSRAM reset sequence has finished.
REQ-014 ram_ce_b, ram_clk, ram_si  out  1 each  PSRAM SPI pins; ram_so  in  1  PSRAM data out.

Function
REQ-015 States: WAIT, RSTEN, GAP1, RST, GAP2, IDLE, SHIFT, GAP3.
REQ-016 WAIT counts INIT_CYCLES clk cycles, then enters RSTEN.
REQ-017 RSTEN and RST each send one 8-bit frame: 0x66, then 0x99.
REQ-018 GAP1 separates the two frames; GAP2 follows 0x99.
REQ-019 GAP1 and GAP2 each hold ram_ce_b high for GAP_CYCLES; after GAP2, init_done rises and state goes to IDLE.
REQ-020 req_ready is high only in IDLE.
REQ-021 A request is accepted on the cycle where req_valid and req_ready are both high; req_write, req_addr and req_wdata are latched that cycle.
REQ-022 An accepted request builds a 64-bit frame, MSB first: command (0x02 write, 0x03 read), then {1'b0, addr}, then wdata (zeros for a read).
REQ-023 Bit timing: each bit takes 2 clk cycles.
REQ-024 Low phase: ram_clk=0 and ram_si=current bit.
REQ-025 High phase: ram_clk=1; ram_so is sampled into the read shift register at the end of this cycle.
REQ-026 SCLK = clk/2; SPI mode 0.
REQ-027 ram_ce_b goes low on the cycle after acceptance, together with the first low phase; it stays low for exactly 128 cycles.
REQ-028 The samples of bits 32..63 form rdata.
REQ-029 On the cycle after the last high phase: ram_ce_b=1, ram_clk=0, and rvalid (read) or wdone (write) pulses; rdata updates in the same cycle as rvalid.
REQ-030 GAP3 holds ram_ce_b high for GAP_CYCLES counted from that cycle, then returns to IDLE.
REQ-031 Back-to-back requests: acceptance to acceptance is at least 129 + GAP_CYCLES cycles.
REQ-032 A request asserted before init_done is held off (req_ready=0), not dropped; the host keeps req_valid high.
REQ-033 req_* changes after acceptance have no effect on the frame in flight.
REQ-034 Address 0x7FFFFF is legal; no wrap handling inside the controller, since the PSRAM wraps internally.

Reset
REQ-035 While reset is high, state=WAIT and counters clear.
REQ-036 Reset values: ram_ce_b=1, ram_clk=0, ram_si=0, req_ready=0, rvalid=0, wdone=0, init_done=0, rdata=0.
REQ-037 Reset asserted mid-frame aborts the frame: ram_ce_b=1 on the next cycle, no rvalid or wdone, and the full init sequence reruns.

Structure
REQ-038 Package psram_pkg holds: command constants CMD_RSTEN=0x66, CMD_RST=0x99, CMD_WRITE=0x02, CMD_READ=0x03; the state encoding; FRAME_BITS=64.
REQ-039 One sub-module, psram_shifter: it shifts out an N-bit frame and shifts in ram_so with the timing above. psram_ctrl instantiates it for both the 8-bit init frames and the 64-bit access frames.

Verification
REQ-040 The bench uses INIT_CYCLES=4 and a behavioural PSRAM model: SPI mode 0, 8 MB array.
REQ-041 Reset release: ram_ce_b frames of 8 bits carrying 0x66, then 0x99, are observed; init_done rises; req_ready is not high before init_done.
REQ-042 Write 0xDEADBEEF at 0x000100, then read 0x000100: the model sees bytes DE AD BE EF at 0x100..0x103, and rdata=0xDEADBEEF with a single rvalid pulse.
REQ-043 ram_clk is counted during a read frame: exactly 64 rising edges while ram_ce_b=0, and ram_si is stable across every rising edge.
REQ-044 req_valid is held high continuously for two requests: the second acceptance occurs exactly 129+GAP_CYCLES cycles after the first.
REQ-045 Reset is pulsed at cycle 40 of a write to 0x7FFFFC: no wdone; ram_ce_b=1 the next cycle; the init frames repeat; the model byte at 0x7FFFFC is unchanged or partial, never a complete new word.
REQ-046 Read of 0x7FFFFF with the model preloaded 0x5A at 0x7FFFFF and 0xA5 at 0x000000: rdata[31:16]=0x5AA5, confirming model wrap.
